// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared byte and sequencer-state types for the UART transmit FIFO
package uart_pkg;

  // One character on the wire.
  typedef logic [7:0] uart_byte_t;

  // Frame sequencer states: waiting for data, frame running, one-clock rearm gap.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } tx_seq_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// rtl/uart_fifo_mem.sv - Depth x 8 byte storage, clocked write, combinational read
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int Depth = 16,
  localparam int AddrW = $clog2(Depth)
) (
  input  logic             clock,
  input  logic             i_wr_en,
  input  logic [AddrW-1:0] i_wr_addr,
  input  uart_byte_t       i_wr_data,
  input  logic [AddrW-1:0] i_rd_addr,
  output uart_byte_t       o_rd_data
);

  // Contents are not reset: the pointers alone decide what is valid.
  uart_byte_t r_mem [Depth];

  // Store the incoming byte at the write address.
  always_ff @(posedge clock) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  // Head byte is visible without a clock so the sequencer can load it directly.
  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO and frame sequencer feeding a UART serializer; optional UART_TX_FIFO_OVF_EN adds ovf_clr/overflow
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int Depth = 16,
  localparam int CountW = $clog2(Depth + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [7:0]        wr_data,
  output logic              full,
  output logic              empty,
  output logic [CountW-1:0] count,
  output logic              busy,
  output logic              txen,
  output logic [7:0]        txdata,
  input  logic              cts
`ifdef UART_TX_FIFO_OVF_EN
  ,
  input  logic              ovf_clr,
  output logic              overflow
`endif
);

  localparam int AddrW = $clog2(Depth);

  logic [AddrW-1:0]  r_wr_ptr;
  logic [AddrW-1:0]  r_rd_ptr;
  logic [CountW-1:0] r_count;
  logic              r_full;
  logic              r_empty;
  logic              r_txen;
  logic              r_cts_seen;
  uart_byte_t        r_txdata;
  tx_seq_state_t     r_state;

  logic              w_push;
  logic              w_pop;
  uart_byte_t        w_head;
  logic [CountW-1:0] w_count_nxt;

  // A write is taken only when the registered full flag allows it, even if a
  // pop frees a slot in the same clock.
  assign w_push = wr_en && !r_full;

  // The byte in flight leaves the FIFO once its stop bit has been seen and ended.
  assign w_pop = (r_state == SEND) && r_cts_seen && !cts;

  uart_fifo_mem #(
    .Depth(Depth)
  ) u_mem (
    .clock     (clock),
    .i_wr_en   (w_push),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (wr_data),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_head)
  );

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  // Pointers, occupancy and the flags derived from it, all updated together.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == CountW'(Depth));
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Frame sequencer: present the head byte, wait out the stop bit, then drop
  // txen for one clock so the serializer rearms before the next frame.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_txen     <= 1'b0;
      r_txdata   <= '0;
      r_cts_seen <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_count != '0) begin
            r_state    <= SEND;
            r_txen     <= 1'b1;
            r_txdata   <= w_head;
            r_cts_seen <= 1'b0;
          end
        end
        SEND: begin
          if (cts) begin
            r_cts_seen <= 1'b1;
          end else if (r_cts_seen) begin
            r_txen  <= 1'b0;
            r_state <= GAP;
          end
        end
        GAP: begin
          // r_count already reflects the pop that ended the previous frame.
          if (r_count != '0) begin
            r_state    <= SEND;
            r_txen     <= 1'b1;
            r_txdata   <= w_head;
            r_cts_seen <= 1'b0;
          end else begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
          r_txen  <= 1'b0;
        end
      endcase
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic r_overflow;

  // Sticky record of a dropped write; a new drop wins over a clear in the same clock.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (wr_en && r_full) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  assign overflow = r_overflow;
`endif

  assign full   = r_full;
  assign empty  = r_empty;
  assign count  = r_count;
  assign busy   = (r_state != IDLE);
  assign txen   = r_txen;
  assign txdata = r_txdata;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo driving a model serializer
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int Depth     = 16;
  localparam int CountW    = $clog2(Depth + 1);
  localparam int BitClks   = 9;
  localparam int StopStart = 9 * BitClks;
  localparam int FrameClks = 10 * BitClks;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic full, empty, busy, txen, cts;
  logic [CountW-1:0] count;
  logic [7:0] txdata;
`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_clr = 1'b0;
  logic overflow;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  uart_byte_t exp_q[$];

  always #5 clock = ~clock;

  uart_tx_fifo #(.Depth(Depth)) dut (
    .clock   (clock),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .empty   (empty),
    .count   (count),
    .busy    (busy),
    .txen    (txen),
    .txdata  (txdata),
    .cts     (cts)
`ifdef UART_TX_FIFO_OVF_EN
    ,
    .ovf_clr (ovf_clr),
    .overflow(overflow)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Serializer model: 9 clocks per bit, start + 8 data (LSB first) + stop.
  int ser_t = 0;
  logic [7:0] ser_shift = 8'h00;
  logic line;

  always @(posedge clock) begin
    if (!txen) begin
      ser_t <= 0;
    end else begin
      if (ser_t == BitClks - 1) ser_shift <= txdata;
      if (ser_t < FrameClks) ser_t <= ser_t + 1;
    end
  end

  function automatic logic line_level(input logic en, input int t, input logic [7:0] sh);
    if (!en || t >= StopStart) return 1'b1;
    if (t < BitClks) return 1'b0;
    return sh[(t - BitClks) / BitClks];
  endfunction

  assign line = line_level(txen, ser_t, ser_shift);
  assign cts  = txen && (ser_t >= StopStart) && (ser_t < FrameClks);

  // Line decoder and scoreboard compare, mid-bit sampling.
  logic [7:0] dec_byte = 8'h00;
  always @(negedge clock) begin
    if (txen) begin
      if (ser_t == 4) check("start_bit", line, 0);
      for (int k = 1; k <= 8; k++) begin
        if (ser_t == 4 + BitClks * k) dec_byte[k-1] <= line;
      end
      if (ser_t == StopStart + 4) begin
        check("stop_bit", line, 1);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", dec_byte, -1);
        end else begin
          check("frame_data", dec_byte, exp_q[0]);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Stop-bit width and rearm-gap width monitors.
  int cts_run = 0;
  int gap_run = 0;
  always @(negedge clock) begin
    if (cts) begin
      cts_run <= cts_run + 1;
    end else if (cts_run != 0) begin
      check("stop_len", cts_run, BitClks);
      cts_run <= 0;
    end
    if (!busy) begin
      gap_run <= 0;
    end else if (!txen) begin
      gap_run <= gap_run + 1;
    end else if (gap_run != 0) begin
      check("gap_len", gap_run, 1);
      gap_run <= 0;
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    check("drain_timeout", busy, 0);
  endtask

  typedef struct {
    logic              wr;
    uart_byte_t        d;
    logic [CountW-1:0] c;
    logic              f;
    logic              e;
  } vec_t;

  vec_t tbl[20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int pushed;
    int nf;
    int falls[3];
    int k;
    logic prev_txen;
    int txen_seen;

    for (int i = 0; i < 20; i++) begin
      tbl[i].wr = (i < 17);
      tbl[i].d  = 8'h40 + 8'(i);
      tbl[i].c  = CountW'((i + 1 > Depth) ? Depth : i + 1);
      tbl[i].f  = (i >= Depth - 1);
      tbl[i].e  = 1'b0;
    end

    // Reset state and idle line.
    @(negedge clock);
    @(negedge clock);
    check("rst_txen", txen, 0);
    check("rst_txdata", txdata, 0);
    check("rst_flags", {full, empty, busy}, 3'b010);
    check("rst_count", count, 0);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle", {txen, empty, busy, count}, {1'b0, 1'b1, 1'b0, 5'd0});
    end

    // Single byte: latency and full decoded frame.
    wr_en = 1'b1; wr_data = 8'hA5; exp_q.push_back(8'hA5);
    tick();
    wr_en = 1'b0;
    check("lat_count", count, 1);
    check("lat_txen0", txen, 0);
    tick();
    check("lat_txen1", txen, 1);
    check("lat_txdata", txdata, 8'hA5);
    wait_idle(300);
    check("a5_count", count, 0);
    check("a5_empty", empty, 1);
    check("a5_txen", txen, 0);
    check("a5_scoreboard", exp_q.size(), 0);

    // Three back-to-back frames; count at each txen fall.
    for (int i = 1; i <= 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h11 * i); exp_q.push_back(8'(8'h11 * i));
      tick();
    end
    wr_en = 1'b0;
    check("three_count", count, 3);
    nf = 0; k = 0; prev_txen = txen;
    while (busy && k < 600) begin
      tick();
      k++;
      if (prev_txen && !txen && nf < 3) begin
        falls[nf] = count;
        nf++;
      end
      prev_txen = txen;
    end
    check("three_timeout", busy, 0);
    check("three_nfalls", nf, 3);
    check("three_fall0", falls[0], 2);
    check("three_fall1", falls[1], 1);
    check("three_fall2", falls[2], 0);
    check("three_scoreboard", exp_q.size(), 0);

    // Table: 17 writes into a 16-deep FIFO, then hold.
    pushed = 0;
    for (int i = 0; i < 20; i++) begin
      wr_en   = tbl[i].wr;
      wr_data = tbl[i].d;
      if (tbl[i].wr && pushed < Depth) begin
        exp_q.push_back(tbl[i].d);
        pushed++;
      end
      tick();
      check($sformatf("tbl%0d_count", i), count, tbl[i].c);
      check($sformatf("tbl%0d_flags", i), {full, empty}, {tbl[i].f, tbl[i].e});
    end
    wr_en = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    check("ovf_set", overflow, 1);
    wr_en = 1'b1; wr_data = 8'hDD; ovf_clr = 1'b1;
    tick();
    check("ovf_set_beats_clr", overflow, 1);
    wr_en = 1'b0;
    tick();
    check("ovf_clr", overflow, 0);
    ovf_clr = 1'b0;
`endif

    // Write while full on the clock that pops the first byte.
    k = 0;
    while (!(txen && ser_t == FrameClks) && k < 300) begin
      tick();
      k++;
    end
    check("pop_align_timeout", (k < 300) ? 1 : 0, 1);
    wr_en = 1'b1; wr_data = 8'hEE;
    tick();
    wr_en = 1'b0;
    check("full_pop_count", count, Depth - 1);
    check("full_pop_full", full, 0);
    wait_idle(2000);
    check("full_scoreboard", exp_q.size(), 0);
    check("full_drained_count", count, 0);

    // Reset mid data bit of frame 2 of 4.
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = 8'h81 + 8'(i); exp_q.push_back(8'h81 + 8'(i));
      tick();
    end
    wr_en = 1'b0;
    k = 0;
    while (!(exp_q.size() == 3 && txen && ser_t == 30) && k < 400) begin
      tick();
      k++;
    end
    check("mid_align_timeout", (k < 400) ? 1 : 0, 1);
    #2 reset = 1'b0;
    #1;
    check("async_txen", txen, 0);
    check("async_count", count, 0);
    check("async_flags", {full, empty, busy}, 3'b010);
    check("async_line", line, 1);
    exp_q.delete();
    @(negedge clock);
    reset = 1'b1;
    txen_seen = 0;
    for (int i = 0; i < 150; i++) begin
      tick();
      if (txen || !line) txen_seen++;
    end
    check("post_reset_quiet", txen_seen, 0);
    check("post_reset_count", count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
